fixed_point_best_tracker: RTL and testbench

Sequential best-fitness tracker for the optimizer datapath. It streams one fitness value per agent through a single shared signed fixed-point comparator (`FIXED_POINT_COMP`) and finds the run-best value and its agent index. It then time-multiplexes the same comparator to merge the run-best into a persistent global best: the swarm target kept across iterations. It sits between the fitness-evaluation pipeline and the position-update stage.

---
 rtl/fixed_point_best_tracker_pkg.sv | 13 +
 rtl/FIXED_POINT_COMP.sv | 18 +
 rtl/fixed_point_best_tracker.sv | 125 ++++++++++++
 tb/tb_fixed_point_best_tracker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_best_tracker_pkg.sv
// Shared definitions for the best-fitness tracker: FSM encoding and optimisation mode constants.
package fixed_point_best_tracker_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StMerge = 2'd2
    } tracker_state_e;

    localparam bit MODE_MIN = 1'b1;
    localparam bit MODE_MAX = 1'b0;

endpackage

// File: rtl/FIXED_POINT_COMP.sv
// Signed two's-complement magnitude comparator shared by the run scan and the global merge.
module FIXED_POINT_COMP #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);

    always_comb begin
        LT = $signed(A) <  $signed(B);
        EQ = A == B;
        GT = $signed(A) >  $signed(B);
    end

endmodule

// File: rtl/fixed_point_best_tracker.sv
// Streams N_AGENTS fitness values through one comparator to find the run-best,
// then reuses that comparator for one cycle to fold the run-best into a persistent global best.
module fixed_point_best_tracker
    import fixed_point_best_tracker_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N_AGENTS = 16,
    parameter bit          MINIMIZE = MODE_MIN
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        START_IN,
    input  logic                        CLEAR_GLOBAL_IN,
    input  logic [WIDTH-1:0]            VALUE_IN,
    input  logic                        VALUE_VALID_IN,
    output logic                        VALUE_READY_OUT,
    output logic                        BUSY_OUT,
    output logic [WIDTH-1:0]            RUN_BEST_OUT,
    output logic [$clog2(N_AGENTS)-1:0] RUN_INDEX_OUT,
    output logic                        DONE_OUT,
    output logic [WIDTH-1:0]            GLOBAL_BEST_OUT,
    output logic                        GLOBAL_VALID_OUT,
    output logic                        GLOBAL_UPDATED_OUT
);

    localparam int unsigned IDX_W = $clog2(N_AGENTS);

    tracker_state_e   state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [WIDTH-1:0] run_best_q;
    logic [IDX_W-1:0] run_index_q;
    logic [WIDTH-1:0] global_best_q;
    logic             global_valid_q;
    logic             updated_q;

    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             cmp_lt, cmp_gt, unused_cmp_eq;
    logic             better;
    logic             beat_acc;
    logic             last_beat;

    // Scan compares the incoming beat to the incumbent; merge compares run-best to global.
    always_comb begin
        cmp_a = VALUE_IN;
        cmp_b = run_best_q;
        if (state_q == StMerge) begin
            cmp_a = run_best_q;
            cmp_b = global_best_q;
        end
    end

    FIXED_POINT_COMP #(
        .WIDTH(WIDTH)
    ) u_comp (
        .A (cmp_a),
        .B (cmp_b),
        .LT(cmp_lt),
        .EQ(unused_cmp_eq),
        .GT(cmp_gt)
    );

    assign better    = (MINIMIZE == MODE_MIN) ? cmp_lt : cmp_gt;
    assign beat_acc  = VALUE_VALID_IN && (state_q == StScan);
    assign last_beat = cnt_q == IDX_W'(N_AGENTS - 1);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            run_best_q     <= '0;
            run_index_q    <= '0;
            global_best_q  <= '0;
            global_valid_q <= 1'b0;
            updated_q      <= 1'b0;
        end else begin
            updated_q <= 1'b0;
            if (CLEAR_GLOBAL_IN) begin
                global_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (START_IN) begin
                        state_q <= StScan;
                        cnt_q   <= '0;
                    end
                end
                StScan: begin
                    if (beat_acc) begin
                        // Strictly-better only, so ties keep the lowest index.
                        if (cnt_q == '0 || better) begin
                            run_best_q  <= VALUE_IN;
                            run_index_q <= cnt_q;
                        end
                        if (last_beat) begin
                            state_q <= StMerge;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StMerge: begin
                    state_q <= StIdle;
                    // A same-cycle clear makes global invalid, so the run-best always wins.
                    if (CLEAR_GLOBAL_IN || !global_valid_q || better) begin
                        global_best_q  <= run_best_q;
                        global_valid_q <= 1'b1;
                        updated_q      <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign VALUE_READY_OUT    = state_q == StScan;
    assign BUSY_OUT           = state_q != StIdle;
    assign DONE_OUT           = state_q == StMerge;
    assign RUN_BEST_OUT       = run_best_q;
    assign RUN_INDEX_OUT      = run_index_q;
    assign GLOBAL_BEST_OUT    = global_best_q;
    assign GLOBAL_VALID_OUT   = global_valid_q;
    assign GLOBAL_UPDATED_OUT = updated_q;

endmodule

// File: tb/tb_fixed_point_best_tracker.sv
// Scoreboard bench: a minimising and a maximising tracker share one stimulus stream.
module tb_fixed_point_best_tracker;

    typedef logic [3:0][7:0] beats_t;

    typedef struct packed {
        logic [1:0][7:0] rb;
        logic [1:0][1:0] ri;
        logic [1:0]      upd;
        logic [1:0][7:0] gb;
        logic [1:0]      gv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic       vvalid = 1'b0;
    logic [7:0] value = 8'd0;

    logic       m_ready, m_busy, m_done, m_gvalid, m_gupd;
    logic [7:0] m_rb, m_gb;
    logic [1:0] m_ri;
    logic       x_ready, x_busy, x_done, x_gvalid, x_gupd;
    logic [7:0] x_rb, x_gb;
    logic [1:0] x_ri;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       exp_q[$];
    exp_t       cur;
    bit         glob_pending = 1'b0;
    logic [1:0][7:0] mdl_gb;
    logic [1:0]      mdl_gv;

    always #5 clk = ~clk;

    fixed_point_best_tracker #(.WIDTH(8), .N_AGENTS(4), .MINIMIZE(1'b1)) u_min (
        .CLK(clk), .RSTN(rstn), .START_IN(start), .CLEAR_GLOBAL_IN(clr),
        .VALUE_IN(value), .VALUE_VALID_IN(vvalid), .VALUE_READY_OUT(m_ready),
        .BUSY_OUT(m_busy), .RUN_BEST_OUT(m_rb), .RUN_INDEX_OUT(m_ri), .DONE_OUT(m_done),
        .GLOBAL_BEST_OUT(m_gb), .GLOBAL_VALID_OUT(m_gvalid), .GLOBAL_UPDATED_OUT(m_gupd)
    );

    fixed_point_best_tracker #(.WIDTH(8), .N_AGENTS(4), .MINIMIZE(1'b0)) u_max (
        .CLK(clk), .RSTN(rstn), .START_IN(start), .CLEAR_GLOBAL_IN(clr),
        .VALUE_IN(value), .VALUE_VALID_IN(vvalid), .VALUE_READY_OUT(x_ready),
        .BUSY_OUT(x_busy), .RUN_BEST_OUT(x_rb), .RUN_INDEX_OUT(x_ri), .DONE_OUT(x_done),
        .GLOBAL_BEST_OUT(x_gb), .GLOBAL_VALID_OUT(x_gvalid), .GLOBAL_UPDATED_OUT(x_gupd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beats_t pack4(input int a, input int b, input int c, input int d);
        beats_t v;
        v[0] = 8'(a);
        v[1] = 8'(b);
        v[2] = 8'(c);
        v[3] = 8'(d);
        return v;
    endfunction

    // Reference: best = first extreme value in arrival order; merge on invalid, clear or strict win.
    function automatic exp_t model(input beats_t vals, input bit clr_merge);
        exp_t e;
        logic signed [7:0] rb, v, gb;
        int ri;
        for (int m = 0; m < 2; m++) begin
            rb = $signed(vals[0]);
            ri = 0;
            for (int i = 1; i < 4; i++) begin
                v = $signed(vals[i]);
                if ((m == 0) ? (v < rb) : (v > rb)) begin
                    rb = v;
                    ri = i;
                end
            end
            gb = $signed(mdl_gb[m]);
            e.rb[m]  = rb;
            e.ri[m]  = 2'(ri);
            e.upd[m] = clr_merge || !mdl_gv[m] || ((m == 0) ? (rb < gb) : (rb > gb));
            if (e.upd[m]) begin
                mdl_gb[m] = rb;
                mdl_gv[m] = 1'b1;
            end
            e.gb[m] = mdl_gb[m];
            e.gv[m] = mdl_gv[m];
        end
        return e;
    endfunction

    // gaps: 0 = back-to-back, 1 = fixed valid pattern, 2 = random valid
    task automatic do_run(input beats_t vals, input int gaps, input bit mid_start,
                          input bit clr_merge);
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        logic [6:0] pat = 7'b1101001;
        exp_q.push_back(model(vals, clr_merge));
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        while (i < 4 && cyc < 100) begin
            case (gaps)
                0:       vvalid = 1'b1;
                1:       vvalid = (cyc < 7) ? pat[cyc] : 1'b1;
                default: vvalid = 1'($urandom_range(0, 1));
            endcase
            value = vals[i];
            if (mid_start) start = 1'($urandom_range(0, 1));
            acc = vvalid && m_ready;
            @(posedge clk) #1;
            if (acc) i++;
            cyc++;
        end
        start  = 1'b0;
        vvalid = 1'b0;
        if (i < 4) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got %0d beats accepted expected 4", i);
        end
        check("done_after_last_beat", {m_done, x_done, m_ready, x_ready}, 4'b1100);
        clr = clr_merge;
        @(posedge clk) #1;
        clr = 1'b0;
        check("idle_after_merge", {m_busy, x_busy}, 2'b00);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (glob_pending) begin
            glob_pending = 1'b0;
            check("min_gupd",   m_gupd,   cur.upd[0]);
            check("min_gvalid", m_gvalid, cur.gv[0]);
            check("min_gbest",  m_gb,     cur.gb[0]);
            check("max_gupd",   x_gupd,   cur.upd[1]);
            check("max_gvalid", x_gvalid, cur.gv[1]);
            check("max_gbest",  x_gb,     cur.gb[1]);
        end else if (rstn) begin
            check("no_spurious_gupd", {m_gupd, x_gupd}, 2'b00);
        end
        if (m_done || x_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=%b%b expected no done", m_done, x_done);
            end else begin
                cur = exp_q.pop_front();
                check("done_both", {m_done, x_done}, 2'b11);
                check("min_run_best",  m_rb, cur.rb[0]);
                check("min_run_index", m_ri, cur.ri[0]);
                check("max_run_best",  x_rb, cur.rb[1]);
                check("max_run_index", x_ri, cur.ri[1]);
                glob_pending = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mdl_gb = '0;
        mdl_gv = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_min_outs", {m_ready, m_busy, m_done, m_rb, m_ri, m_gb, m_gvalid, m_gupd}, '0);
        check("reset_max_outs", {x_ready, x_busy, x_done, x_rb, x_ri, x_gb, x_gvalid, x_gupd}, '0);
        rstn = 1'b1;
        @(posedge clk) #1;

        do_run(pack4(5, -3, 7, -3), 0, 1'b0, 1'b0);
        do_run(pack4(5, -3, 7, -3), 1, 1'b1, 1'b0);
        do_run(pack4(0, 1, 2, -3), 0, 1'b0, 1'b0);
        do_run(pack4(0, -128, 0, 0), 0, 1'b0, 1'b0);
        do_run(pack4(127, -128, 0, -1), 2, 1'b0, 1'b0);
        do_run(pack4(10, 20, 30, 40), 0, 1'b0, 1'b1);

        // Clear while idle drops valid on the next cycle.
        clr = 1'b1;
        @(posedge clk) #1;
        clr = 1'b0;
        check("clear_idle_valid", {m_gvalid, x_gvalid}, 2'b00);
        mdl_gv = '0;

        // Abort after two accepted beats.
        start = 1'b1;
        @(posedge clk) #1;
        start  = 1'b0;
        vvalid = 1'b1;
        value  = 8'd33;
        repeat (2) @(posedge clk);
        #1;
        vvalid = 1'b0;
        rstn   = 1'b0;
        #1;
        check("abort_min_outs", {m_ready, m_busy, m_done, m_rb, m_ri, m_gb, m_gvalid, m_gupd}, '0);
        check("abort_max_outs", {x_ready, x_busy, x_done, x_rb, x_ri, x_gb, x_gvalid, x_gupd}, '0);
        mdl_gb = '0;
        mdl_gv = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk) #1;
        do_run(pack4(-7, 3, -7, 100), 0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            do_run(pack4(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
